// File: rtl/map_loader.sv
// Copies the maze wall ROM rows into on-chip RAM, then reads every row back and checks it.
// 32 cycles from an accepted start to the one-cycle done pulse; start is ignored while busy.
module map_loader #(
    parameter logic [9:0] H_BASE = 10'h000,
    parameter logic [9:0] V_BASE = 10'h008,
    parameter int         H_ROWS = 8,
    parameter int         V_ROWS = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [9:0] err_addr,
    output logic [3:0] h_addr,
    input  logic [6:0] h_data,
    output logic [3:0] v_addr,
    input  logic [7:0] v_data,
    output logic [9:0] mem_addr,
    output logic [7:0] mem_din,
    output logic       mem_we,
    input  logic [7:0] mem_dout
);

    localparam logic [4:0] H_LAST = 5'(H_ROWS - 1);
    localparam logic [4:0] V_LAST = 5'(V_ROWS - 1);
    localparam logic [4:0] K_LAST = 5'(H_ROWS + V_ROWS - 1);
    localparam logic [4:0] H_CNT  = 5'(H_ROWS);

    typedef enum logic [2:0] {
        IDLE,
        WR_H,
        WR_V,
        CHK,
        FIN
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [4:0] idx;
    logic [4:0] v_idx;
    logic [7:0] chk_exp;
    logic [7:0] exp_q;
    logic [9:0] addr_q;
    logic       chk_vld_q;
    logic       mismatch;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = WR_H;
            WR_H: if (idx == H_LAST) state_nxt = WR_V;
            WR_V: if (idx == V_LAST) state_nxt = CHK;
            CHK:  if (idx == K_LAST) state_nxt = FIN;
            FIN:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Row index restarts at zero on every state entry and stays parked in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx <= '0;
        end else if (state_nxt != state || state == IDLE) begin
            idx <= '0;
        end else begin
            idx <= idx + 5'd1;
        end
    end

    assign v_idx = idx - H_CNT;

    // Output logic: ROM selects, RAM port and the expected byte for the verify pass.
    always_comb begin
        busy     = (state != IDLE);
        h_addr   = '0;
        v_addr   = '0;
        mem_addr = '0;
        mem_din  = '0;
        mem_we   = 1'b0;
        chk_exp  = '0;
        case (state)
            WR_H: begin
                h_addr   = idx[3:0];
                mem_addr = H_BASE + {5'd0, idx};
                mem_din  = {1'b0, h_data};
                mem_we   = 1'b1;
            end
            WR_V: begin
                v_addr   = idx[3:0];
                mem_addr = V_BASE + {5'd0, idx};
                mem_din  = v_data;
                mem_we   = 1'b1;
            end
            CHK: begin
                if (idx < H_CNT) begin
                    h_addr   = idx[3:0];
                    mem_addr = H_BASE + {5'd0, idx};
                    chk_exp  = {1'b0, h_data};
                end else begin
                    v_addr   = v_idx[3:0];
                    mem_addr = V_BASE + {5'd0, v_idx};
                    chk_exp  = v_data;
                end
            end
            default: ;
        endcase
    end

    // RAM read data lags the address by a cycle, so the expectation is delayed to match.
    always_ff @(posedge clk) begin
        if (rst) begin
            chk_vld_q <= 1'b0;
            exp_q     <= '0;
            addr_q    <= '0;
        end else begin
            chk_vld_q <= (state == CHK);
            exp_q     <= chk_exp;
            addr_q    <= mem_addr;
        end
    end

    assign mismatch = chk_vld_q && (mem_dout != exp_q);

    // Only the first failing address is kept; a new load clears the record.
    always_ff @(posedge clk) begin
        if (rst) begin
            err      <= 1'b0;
            err_addr <= '0;
        end else if (state == IDLE && start) begin
            err      <= 1'b0;
            err_addr <= '0;
        end else if (mismatch && !err) begin
            err      <= 1'b1;
            err_addr <= addr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done <= 1'b0;
        end else begin
            done <= (state == FIN);
        end
    end

endmodule

// File: tb/tb_map_loader.sv
// Bench for map_loader: ROM/RAM models, a reference RAM image and a fault model.
module tb_map_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start;
    logic       busy, done, err, mem_we;
    logic [9:0] err_addr, mem_addr;
    logic [3:0] h_addr, v_addr;
    logic [6:0] h_data;
    logic [7:0] v_data, mem_din, mem_dout;

    logic       busy2, done2, err2, mem_we2;
    logic [9:0] err_addr2, mem_addr2;
    logic [3:0] h_addr2, v_addr2;
    logic [6:0] h_data2;
    logic [7:0] v_data2, mem_din2, mem_dout2;

    logic [6:0] hrom [16];
    logic [7:0] vrom [16];
    logic [7:0] ram  [1024];
    logic [7:0] ram2 [1024];
    logic       fault_en;

    logic [7:0] exp1 [1024];
    logic [7:0] exp2 [1024];
    bit         ev1  [1024];
    bit         ev2  [1024];
    logic       m_err;
    logic [9:0] m_err_addr;

    int checks = 0;
    int errors = 0;

    assign h_data  = hrom[h_addr];
    assign v_data  = vrom[v_addr];
    assign h_data2 = hrom[h_addr2];
    assign v_data2 = vrom[v_addr2];

    map_loader dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
        .err_addr(err_addr), .h_addr(h_addr), .h_data(h_data), .v_addr(v_addr),
        .v_data(v_data), .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we),
        .mem_dout(mem_dout)
    );

    map_loader #(.H_BASE(10'h100), .V_BASE(10'h3F8)) dut2 (
        .clk(clk), .rst(rst), .start(start), .busy(busy2), .done(done2), .err(err2),
        .err_addr(err_addr2), .h_addr(h_addr2), .h_data(h_data2), .v_addr(v_addr2),
        .v_data(v_data2), .mem_addr(mem_addr2), .mem_din(mem_din2), .mem_we(mem_we2),
        .mem_dout(mem_dout2)
    );

    // Fault model: bit 2 of address 3 stuck at 1, address 10 stuck at zero.
    function automatic logic [7:0] faulty(input logic [9:0] a, input logic [7:0] d);
        if (!fault_en) return d;
        if (a == 10'd3) return d | 8'h04;
        if (a == 10'd10) return 8'h00;
        return d;
    endfunction

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_din;
        mem_dout <= faulty(mem_addr, ram[mem_addr]);
        if (mem_we2) ram2[mem_addr2] <= mem_din2;
        mem_dout2 <= ram2[mem_addr2];
    end

    task automatic load_prod();
        for (int i = 0; i < 16; i++) begin
            hrom[i] = (i == 0 || i == 7) ? 7'h7F : 7'h00;
            vrom[i] = 8'h81;
        end
    endtask

    task automatic load_random();
        for (int i = 0; i < 16; i++) begin
            hrom[i] = 7'($urandom);
            vrom[i] = 8'($urandom);
        end
    endtask

    // Reference image of RAM after a load, and the verify verdict under the fault model.
    task automatic build_model();
        logic [9:0] order [$];
        for (int a = 0; a < 1024; a++) begin
            ev1[a] = 1'b0;
            ev2[a] = 1'b0;
        end
        for (int i = 0; i < 8; i++) begin
            exp1[i] = {1'b0, hrom[i]};
            ev1[i] = 1'b1;
            exp2[(256 + i) % 1024] = {1'b0, hrom[i]};
            ev2[(256 + i) % 1024] = 1'b1;
            order.push_back(10'(i));
        end
        for (int i = 0; i < 7; i++) begin
            exp1[8 + i] = vrom[i];
            ev1[8 + i] = 1'b1;
            exp2[(1016 + i) % 1024] = vrom[i];
            ev2[(1016 + i) % 1024] = 1'b1;
            order.push_back(10'(8 + i));
        end
        m_err = 1'b0;
        m_err_addr = '0;
        foreach (order[k]) begin
            if (!m_err && faulty(order[k], exp1[order[k]]) != exp1[order[k]]) begin
                m_err = 1'b1;
                m_err_addr = order[k];
            end
        end
    endtask

    // Pulses start, optionally re-pulses it at cycles p1/p2, and watches both DUTs until done.
    task automatic run_load(input int p1, input int p2, output int dc, output int dc2,
                            output int we1, output int we2, output int bad1,
                            output int bad2, output int busy_bad);
        dc = -1; dc2 = -1; we1 = 0; we2 = 0; bad1 = 0; bad2 = 0; busy_bad = 0;
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            start = (c == p1 || c == p2);
            if (mem_we) begin
                we1++;
                if (!ev1[mem_addr] || exp1[mem_addr] !== mem_din) bad1++;
            end
            if (mem_we2) begin
                we2++;
                if (!ev2[mem_addr2] || exp2[mem_addr2] !== mem_din2) bad2++;
            end
            if (busy !== (c < 32)) busy_bad++;
            if (done2 && dc2 < 0) dc2 = c;
            if (done) begin
                dc = c;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, done, err, err_addr, h_addr, v_addr, mem_addr, mem_din, mem_we} !== 40'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %0h required 0",
                     {busy, done, err, err_addr, h_addr, v_addr, mem_addr, mem_din, mem_we});
        end
        checks++;
        if ({busy2, done2, err2, err_addr2, h_addr2, v_addr2, mem_addr2, mem_din2, mem_we2} !== 40'd0) begin
            errors++;
            $display("FAIL reset_outputs_alt: got %0h required 0",
                     {busy2, done2, err2, err_addr2, h_addr2, v_addr2, mem_addr2, mem_din2, mem_we2});
        end
        rst = 1'b0;
    endtask

    task automatic test_production();
        int dc, dc2, we1, we2, bad1, bad2, bb;
        logic [7:0] want;
        load_prod();
        fault_en = 1'b0;
        build_model();
        run_load(0, 0, dc, dc2, we1, we2, bad1, bad2, bb);
        checks++;
        if (dc !== 32) begin errors++; $display("FAIL prod_done_cycle: got %0d required 32", dc); end
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL prod_err: got %0b required 0", err); end
        checks++;
        if (we1 !== 15) begin errors++; $display("FAIL prod_we_count: got %0d required 15", we1); end
        checks++;
        if (bad1 !== 0) begin errors++; $display("FAIL prod_write_data: got %0d bad writes required 0", bad1); end
        checks++;
        if (bb !== 0) begin errors++; $display("FAIL prod_busy: got %0d bad cycles required 0", bb); end
        for (int a = 0; a < 15; a++) begin
            want = (a == 0 || a == 7) ? 8'h7F : (a < 8) ? 8'h00 : 8'h81;
            checks++;
            if (ram[a] !== want) begin
                errors++;
                $display("FAIL prod_ram[%0d]: got %0h required %0h", a, ram[a], want);
            end
        end
    endtask

    task automatic test_fault();
        int dc, dc2, we1, we2, bad1, bad2, bb;
        load_prod();
        fault_en = 1'b1;
        build_model();
        run_load(0, 0, dc, dc2, we1, we2, bad1, bad2, bb);
        fault_en = 1'b0;
        checks++;
        if (dc !== 32) begin errors++; $display("FAIL fault_done_cycle: got %0d required 32", dc); end
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL fault_err: got %0b required 1", err); end
        checks++;
        if (err_addr !== 10'd3) begin errors++; $display("FAIL fault_err_addr: got %0d required 3", err_addr); end
    endtask

    task automatic test_start_ignored();
        int dc, dc2, we1, we2, bad1, bad2, bb;
        load_prod();
        build_model();
        run_load(5, 20, dc, dc2, we1, we2, bad1, bad2, bb);
        checks++;
        if (dc !== 32) begin errors++; $display("FAIL ignored_done_cycle: got %0d required 32", dc); end
        checks++;
        if (we1 !== 15 || bad1 !== 0) begin
            errors++;
            $display("FAIL ignored_writes: got %0d writes %0d bad required 15 writes 0 bad", we1, bad1);
        end
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL ignored_err: got %0b required 0", err); end
    endtask

    task automatic test_random();
        int dc, dc2, we1, we2, bad1, bad2, bb, ram_bad;
        for (int n = 0; n < 8; n++) begin
            load_random();
            fault_en = 1'($urandom_range(0, 1));
            build_model();
            run_load(0, 0, dc, dc2, we1, we2, bad1, bad2, bb);
            ram_bad = 0;
            for (int a = 0; a < 1024; a++) if (ev1[a] && ram[a] !== exp1[a]) ram_bad++;
            checks++;
            if (dc !== 32 || bb !== 0) begin
                errors++;
                $display("FAIL rand%0d_timing: got done %0d busy_bad %0d required 32 0", n, dc, bb);
            end
            checks++;
            if (we1 !== 15 || bad1 !== 0 || ram_bad !== 0) begin
                errors++;
                $display("FAIL rand%0d_writes: got %0d/%0d/%0d required 15/0/0", n, we1, bad1, ram_bad);
            end
            checks++;
            if (err !== m_err) begin errors++; $display("FAIL rand%0d_err: got %0b required %0b", n, err, m_err); end
            checks++;
            if (err_addr !== m_err_addr) begin
                errors++;
                $display("FAIL rand%0d_err_addr: got %0d required %0d", n, err_addr, m_err_addr);
            end
        end
        fault_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        int dc, dc2, we1, we2, bad1, bad2, bb, dones;
        load_prod();
        build_model();
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 12) rst = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({busy, done, err, err_addr, h_addr, v_addr, mem_addr, mem_din, mem_we} !== 40'd0) begin
            errors++;
            $display("FAIL midrst_outputs: got %0h required 0",
                     {busy, done, err, err_addr, h_addr, v_addr, mem_addr, mem_din, mem_we});
        end
        dones = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) dones++;
        end
        checks++;
        if (dones !== 0) begin errors++; $display("FAIL midrst_no_done: got %0d required 0", dones); end
        run_load(0, 0, dc, dc2, we1, we2, bad1, bad2, bb);
        checks++;
        if (dc !== 32 || err !== 1'b0) begin
            errors++;
            $display("FAIL midrst_reload: got done %0d err %0b required 32 0", dc, err);
        end
    endtask

    task automatic test_back_to_back();
        int dcyc [$];
        logic derr [$];
        load_prod();
        fault_en = 1'b1;
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= 70; c++) begin
            @(negedge clk);
            if (c == 33) begin
                checks++;
                if (err !== 1'b0) begin errors++; $display("FAIL b2b_err_clear: got %0b required 0", err); end
            end
            if (done) begin
                dcyc.push_back(c);
                derr.push_back(err);
                fault_en = 1'b0;
            end
        end
        start = 1'b0;
        for (int c = 0; c < 40 && busy; c++) @(negedge clk);
        checks++;
        if (dcyc.size() !== 2) begin
            errors++;
            $display("FAIL b2b_done_count: got %0d required 2", dcyc.size());
        end else begin
            checks++;
            if (dcyc[0] !== 32 || dcyc[1] !== 64) begin
                errors++;
                $display("FAIL b2b_done_cycles: got %0d %0d required 32 64", dcyc[0], dcyc[1]);
            end
            checks++;
            if (derr[0] !== 1'b1 || derr[1] !== 1'b0) begin
                errors++;
                $display("FAIL b2b_err: got %0b %0b required 1 0", derr[0], derr[1]);
            end
        end
    endtask

    task automatic test_alt_base();
        int dc, dc2, we1, we2, bad1, bad2, bb, ram_bad;
        load_random();
        build_model();
        run_load(0, 0, dc, dc2, we1, we2, bad1, bad2, bb);
        ram_bad = 0;
        for (int i = 0; i < 8; i++) if (ram2[10'h100 + i] !== {1'b0, hrom[i]}) ram_bad++;
        for (int i = 0; i < 7; i++) if (ram2[10'h3F8 + i] !== vrom[i]) ram_bad++;
        checks++;
        if (dc2 !== 32) begin errors++; $display("FAIL alt_done_cycle: got %0d required 32", dc2); end
        checks++;
        if (we2 !== 15 || bad2 !== 0) begin
            errors++;
            $display("FAIL alt_writes: got %0d writes %0d stray/bad required 15 0", we2, bad2);
        end
        checks++;
        if (ram_bad !== 0) begin errors++; $display("FAIL alt_ram: got %0d bad rows required 0", ram_bad); end
        checks++;
        if (err2 !== 1'b0) begin errors++; $display("FAIL alt_err: got %0b required 0", err2); end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        fault_en = 1'b0;
        load_prod();
        test_reset();
        test_production();
        test_fault();
        test_start_ignored();
        test_random();
        test_reset_mid();
        test_back_to_back();
        test_alt_base();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
